// File: rtl/mmio_ctrl_if.sv
// CPU data-memory port as seen by the MMIO slave: address, write strobe/data, RAM read data and muxed read-back.
interface mmio_ctrl_if #(
  parameter int ADDR_W = 12
) ();
  logic [ADDR_W-1:0] addr;
  logic              mwe;
  logic [31:0]       data;
  logic [31:0]       mem_rdata;
  logic [31:0]       data_out;

  modport master (output addr, output mwe, output data, output mem_rdata, input data_out);
  modport slave  (input addr, input mwe, input data, input mem_rdata, output data_out);
endinterface

// File: rtl/mmio_ctrl.sv
// MMIO slave: debounced buttons with W1C rise events and a masked irq, plus RW control registers.
// Reads are combinational with no stall; writes land on the strobe edge; irq is one edge behind state.
module mmio_ctrl #(
  parameter int ADDR_W          = 12,
  parameter int BASE_ADDR       = 1000,
  parameter int NUM_BTNS        = 5,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int NUM_CTRL        = 4,
  parameter int CTRL_W          = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  mmio_ctrl_if.slave                   bus,
  input  logic [NUM_BTNS-1:0]          btn,
  output logic [NUM_CTRL*CTRL_W-1:0]   ctrl_out,
  output logic                         irq
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ADDR_W-1:0] A_LEVEL  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] A_EVENT  = ADDR_W'(BASE_ADDR + 1);
  localparam logic [ADDR_W-1:0] A_MASK   = ADDR_W'(BASE_ADDR + 2);

  logic [ADDR_W-1:0]                    addr;
  logic [NUM_BTNS-1:0]                  sync1, sync2, level, level_nxt;
  logic [NUM_BTNS-1:0]                  event_q, event_nxt, mask, armed, rise, clr;
  logic [NUM_BTNS-1:0][CNT_W-1:0]       cnt, cnt_nxt;
  logic [NUM_CTRL-1:0][CTRL_W-1:0]      ctrl_q;
  logic [NUM_CTRL-1:0]                  ctrl_sel;
  logic [1:0]                           sync_vld;
  logic [31:0]                          rdata;
  logic                                 unused_data;

  assign addr        = bus.addr;
  assign unused_data = ^bus.data;

  always_comb begin
    cnt_nxt   = '0;
    level_nxt = level;
    rise      = '0;
    for (int i = 0; i < NUM_BTNS; i++) begin
      if (sync2[i] != level[i]) begin
        if (cnt[i] == CNT_LAST) begin
          level_nxt[i] = sync2[i];
          rise[i]      = sync2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    ctrl_sel = '0;
    for (int i = 0; i < NUM_CTRL; i++) begin
      ctrl_sel[i] = (addr == ADDR_W'(BASE_ADDR + 3 + i));
    end
  end

  // A button only becomes event-capable once it has been seen released after reset,
  // so a button held through reset settles to level 1 silently.
  assign clr       = (bus.mwe && addr == A_EVENT) ? bus.data[NUM_BTNS-1:0] : '0;
  assign event_nxt = (event_q & ~clr) | (rise & armed);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= '0;
      sync2    <= '0;
      sync_vld <= '0;
      cnt      <= '0;
      level    <= '0;
      armed    <= '0;
      event_q  <= '0;
      mask     <= '0;
      ctrl_q   <= '0;
      irq      <= 1'b0;
    end else begin
      sync1    <= btn;
      sync2    <= sync1;
      sync_vld <= {sync_vld[0], 1'b1};
      cnt      <= cnt_nxt;
      level    <= level_nxt;
      armed    <= armed | ({NUM_BTNS{sync_vld[1]}} & ~sync2);
      event_q  <= event_nxt;
      if (bus.mwe && addr == A_MASK) begin
        mask <= bus.data[NUM_BTNS-1:0];
      end
      for (int i = 0; i < NUM_CTRL; i++) begin
        if (bus.mwe && ctrl_sel[i]) begin
          ctrl_q[i] <= bus.data[CTRL_W-1:0];
        end
      end
      irq <= |(event_q & mask);
    end
  end

  always_comb begin
    rdata = bus.mem_rdata;
    if (addr == A_LEVEL) begin
      rdata = 32'(level);
    end else if (addr == A_EVENT) begin
      rdata = 32'(event_q);
    end else if (addr == A_MASK) begin
      rdata = 32'(mask);
    end else begin
      for (int i = 0; i < NUM_CTRL; i++) begin
        if (ctrl_sel[i]) begin
          rdata = 32'(ctrl_q[i]);
        end
      end
    end
  end

  assign bus.data_out = rdata;
  assign ctrl_out     = ctrl_q;

endmodule

// File: tb/tb_mmio_ctrl.sv
// Scoreboard bench for mmio_ctrl with a short debounce window.
module tb_mmio_ctrl;
  localparam int ADDR_W = 12;
  localparam int BASE   = 1000;
  localparam int NB     = 5;
  localparam int DC     = 4;
  localparam int NC     = 4;
  localparam int CW     = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NB-1:0]     btn = '0;
  logic [NC*CW-1:0]  ctrl_out;
  logic              irq;

  mmio_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  mmio_ctrl #(
    .ADDR_W(ADDR_W), .BASE_ADDR(BASE), .NUM_BTNS(NB),
    .DEBOUNCE_CYCLES(DC), .NUM_CTRL(NC), .CTRL_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .btn(btn), .ctrl_out(ctrl_out), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] obs_q[$];
  int          checks = 0;
  int          failures = 0;

  task automatic want(input string n, input logic [31:0] v);
    exp_t e;
    e.name = n;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int a, output logic [31:0] v);
    bus.addr = ADDR_W'(a);
    #1;
    v = bus.data_out;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    bus.addr = ADDR_W'(a);
    bus.data = d;
    bus.mwe  = 1'b1;
    @(posedge clk);
    #1;
    bus.mwe  = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v, o;
    exp_t e;
    want("init_level", 0); rd(BASE, v);     obs_q.push_back(v);
    want("init_event", 0); rd(BASE + 1, v); obs_q.push_back(v);
    want("init_mask", 0);  rd(BASE + 2, v); obs_q.push_back(v);
    want("init_ctrl", 0);  obs_q.push_back(32'(ctrl_out));
    want("init_irq", 0);   obs_q.push_back(32'(irq));
    wr(BASE + 2, 32'h1F);
    wr(BASE + 4, 32'h5);
    btn[0] = 1'b1;
    repeat (4) tick();
    #2;
    rst_n = 1'b0;
    #1;
    want("rst_ctrl", 0);  obs_q.push_back(32'(ctrl_out));
    want("rst_irq", 0);   obs_q.push_back(32'(irq));
    want("rst_mask", 0);  rd(BASE + 2, v); obs_q.push_back(v);
    want("rst_level", 0); rd(BASE, v);     obs_q.push_back(v);
    want("rst_event", 0); rd(BASE + 1, v); obs_q.push_back(v);
    tick();
    tick();
    rst_n = 1'b1;
    wr(BASE + 2, 32'h1);
    repeat (15) tick();
    want("held_level", 32'h1); rd(BASE, v);     obs_q.push_back(v);
    want("held_event", 0);     rd(BASE + 1, v); obs_q.push_back(v);
    want("held_irq", 0);       obs_q.push_back(32'(irq));
    btn[0] = 1'b0;
    repeat (10) tick();
    want("held_rel_level", 0); rd(BASE, v);     obs_q.push_back(v);
    want("held_rel_event", 0); rd(BASE + 1, v); obs_q.push_back(v);
    wr(BASE + 2, 32'h0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e.val) begin
        failures++;
        $display("FAIL %s: got %h expected %h", e.name, o, e.val);
      end
    end
  endtask

  task automatic test_debounce();
    logic [31:0] v, o;
    exp_t e;
    btn[0] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      want($sformatf("deb_level_edge%0d", k), (k == 6) ? 32'h1 : 32'h0);
      rd(BASE, v);
      obs_q.push_back(v);
    end
    want("deb_event", 32'h1); rd(BASE + 1, v); obs_q.push_back(v);
    want("deb_irq_masked", 0); obs_q.push_back(32'(irq));
    btn[0] = 1'b0;
    repeat (8) tick();
    want("deb_fall_level", 0);     rd(BASE, v);     obs_q.push_back(v);
    want("deb_fall_event", 32'h1); rd(BASE + 1, v); obs_q.push_back(v);
    wr(BASE + 1, 32'h1);
    want("deb_cleared", 0); rd(BASE + 1, v); obs_q.push_back(v);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e.val) begin
        failures++;
        $display("FAIL %s: got %h expected %h", e.name, o, e.val);
      end
    end
  endtask

  task automatic test_glitch();
    logic [31:0] v, o;
    exp_t e;
    btn[2] = 1'b1;
    repeat (3) tick();
    btn[2] = 1'b0;
    repeat (10) tick();
    want("glitch_level", 0); rd(BASE, v);     obs_q.push_back(v);
    want("glitch_event", 0); rd(BASE + 1, v); obs_q.push_back(v);
    btn[2] = 1'b1;
    repeat (4) tick();
    btn[2] = 1'b0;
    repeat (3) tick();
    want("pulse4_level", 32'h4); rd(BASE, v);     obs_q.push_back(v);
    want("pulse4_event", 32'h4); rd(BASE + 1, v); obs_q.push_back(v);
    repeat (6) tick();
    want("pulse4_fall_level", 0); rd(BASE, v); obs_q.push_back(v);
    wr(BASE + 1, 32'h4);
    want("pulse4_cleared", 0); rd(BASE + 1, v); obs_q.push_back(v);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e.val) begin
        failures++;
        $display("FAIL %s: got %h expected %h", e.name, o, e.val);
      end
    end
  endtask

  task automatic test_w1c_irq();
    logic [31:0] v, o;
    exp_t e;
    wr(BASE + 2, 32'h1);
    btn[1:0] = 2'b11;
    repeat (8) tick();
    btn[1:0] = 2'b00;
    repeat (8) tick();
    want("irq_set", 1);        obs_q.push_back(32'(irq));
    want("events_01", 32'h3); rd(BASE + 1, v); obs_q.push_back(v);
    wr(BASE + 1, 32'h1);
    want("w1c_bit0", 32'h2);  rd(BASE + 1, v); obs_q.push_back(v);
    want("irq_lag", 1);       obs_q.push_back(32'(irq));
    tick();
    want("irq_clear", 0);     obs_q.push_back(32'(irq));
    wr(BASE + 2, 32'h2);
    want("irq_mask_lag", 0);  obs_q.push_back(32'(irq));
    tick();
    want("irq_mask_bit1", 1); obs_q.push_back(32'(irq));
    wr(BASE + 1, 32'h2);
    tick();
    want("irq_all_clear", 0); obs_q.push_back(32'(irq));
    want("events_none", 0);   rd(BASE + 1, v); obs_q.push_back(v);
    wr(BASE + 2, 32'h0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e.val) begin
        failures++;
        $display("FAIL %s: got %h expected %h", e.name, o, e.val);
      end
    end
  endtask

  task automatic test_collision();
    logic [31:0] v, o;
    exp_t e;
    btn[0] = 1'b1;
    repeat (5) tick();
    wr(BASE + 1, 32'h1);
    want("coll_level", 32'h1); rd(BASE, v);     obs_q.push_back(v);
    want("coll_set_wins", 32'h1); rd(BASE + 1, v); obs_q.push_back(v);
    wr(BASE + 1, 32'h1);
    want("coll_later_clear", 0); rd(BASE + 1, v); obs_q.push_back(v);
    btn[0] = 1'b0;
    repeat (8) tick();
    want("coll_release", 0); rd(BASE, v); obs_q.push_back(v);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e.val) begin
        failures++;
        $display("FAIL %s: got %h expected %h", e.name, o, e.val);
      end
    end
  endtask

  task automatic test_ctrl_decode();
    logic [31:0] v, o;
    exp_t e;
    wr(BASE + 3, 32'hFFFF_FFF7);
    want("ctrl0_out", 32'h0007);  obs_q.push_back(32'(ctrl_out));
    want("ctrl0_read", 32'h7);    rd(BASE + 3, v); obs_q.push_back(v);
    wr(BASE + 4, 32'hA);
    wr(BASE + 6, 32'h1234_5673);
    want("ctrl_all_out", 32'h30A7); obs_q.push_back(32'(ctrl_out));
    want("ctrl3_read", 32'h3);    rd(BASE + 6, v); obs_q.push_back(v);
    want("ctrl2_read", 32'h0);    rd(BASE + 5, v); obs_q.push_back(v);
    want("mem_addr5", 32'hDEAD_BEEF);    rd(5, v);        obs_q.push_back(v);
    want("mem_past_ctrl", 32'hDEAD_BEEF); rd(BASE + 7, v); obs_q.push_back(v);
    want("mem_below_base", 32'hDEAD_BEEF); rd(BASE - 1, v); obs_q.push_back(v);
    bus.mem_rdata = 32'h1234_5678;
    want("mem_follow", 32'h1234_5678); rd(5, v); obs_q.push_back(v);
    wr(BASE + 7, 32'hFFFF_FFFF);
    wr(5, 32'hFFFF_FFFF);
    want("ctrl_unmapped_wr", 32'h30A7); obs_q.push_back(32'(ctrl_out));
    wr(BASE, 32'h1F);
    want("level_ro", 0); rd(BASE, v); obs_q.push_back(v);
    wr(BASE + 2, 32'hFFFF_FFFF);
    want("mask_trunc", 32'h1F); rd(BASE + 2, v); obs_q.push_back(v);
    wr(BASE + 2, 32'h0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e.val) begin
        failures++;
        $display("FAIL %s: got %h expected %h", e.name, o, e.val);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    bus.addr      = '0;
    bus.mwe       = 1'b0;
    bus.data      = '0;
    bus.mem_rdata = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    tick();
    test_reset();
    test_debounce();
    test_glitch();
    test_w1c_irq();
    test_collision();
    test_ctrl_decode();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
